// File: rtl/bus_spider_reset_seq.sv
// Per-core reset sequencer: synchronised requests, stretched/staggered release, last-cause report.
// Optional watchdog (adds heartbeat_i) enabled by defining BUS_SPIDER_RESET_SEQ_WDT_EN.
module bus_spider_reset_seq #(
   parameter int unsigned NUM_CORES      = 2,
   parameter int unsigned SYNC_STAGES    = 2,
   parameter int unsigned HOLD_CYCLES    = 16,
   parameter int unsigned STAGGER_CYCLES = 8,
   parameter int unsigned WDT_CYCLES     = 1048576
) (
   input  logic                   wb_clk,
   input  logic                   wb_rst_n,
   input  logic                   pll_rst_i,
   input  logic [NUM_CORES-1:0]   host_rst_i,
`ifdef BUS_SPIDER_RESET_SEQ_WDT_EN
   input  logic [NUM_CORES-1:0]   heartbeat_i,
`endif
   output logic [NUM_CORES-1:0]   core_rst_o,
   output logic                   all_run_o,
   output logic [2*NUM_CORES-1:0] cause_o
);

   localparam int unsigned CNT_W = $clog2(HOLD_CYCLES + (NUM_CORES-1)*STAGGER_CYCLES + 1);
   localparam logic [1:0]  CAUSE_GLOBAL = 2'd0;
   localparam logic [1:0]  CAUSE_HOST   = 2'd1;

   typedef enum logic [1:0] {ST_ASSERT, ST_HOLD, ST_RUN} state_e;

   if (NUM_CORES < 1 || NUM_CORES > 8 || SYNC_STAGES < 2 || HOLD_CYCLES < 1 || WDT_CYCLES < 1)
   begin : g_param_check
      $error("bus_spider_reset_seq: illegal parameter value");
   end

   logic [SYNC_STAGES-1:0] pll_sync_q, pll_sync_d;
   logic [NUM_CORES-1:0]   host_sync_q [SYNC_STAGES];
   logic [NUM_CORES-1:0]   host_sync_d [SYNC_STAGES];
   state_e                 state_q [NUM_CORES];
   state_e                 state_d [NUM_CORES];
   logic [CNT_W-1:0]       cnt_q [NUM_CORES];
   logic [CNT_W-1:0]       cnt_d [NUM_CORES];
   logic [NUM_CORES-1:0]   gflag_q, gflag_d;
   logic [2*NUM_CORES-1:0] cause_q, cause_d;
   logic [NUM_CORES-1:0]   core_rst_q, core_rst_d;
   logic                   all_run_q, all_run_d;
   logic                   greq;
   logic [NUM_CORES-1:0]   hreq;

   always_comb begin
      pll_sync_d     = {pll_sync_q[SYNC_STAGES-2:0], pll_rst_i};
      host_sync_d[0] = host_rst_i;
      for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
         host_sync_d[s] = host_sync_q[s-1];
      end
   end

   assign greq = pll_sync_q[SYNC_STAGES-1];
   assign hreq = host_sync_q[SYNC_STAGES-1];

`ifdef BUS_SPIDER_RESET_SEQ_WDT_EN
   localparam int unsigned TMR_W     = $clog2(WDT_CYCLES + 1);
   localparam logic [1:0]  CAUSE_WDT = 2'd2;

   logic [NUM_CORES-1:0] hb_sync_q [SYNC_STAGES];
   logic [NUM_CORES-1:0] hb_sync_d [SYNC_STAGES];
   logic [NUM_CORES-1:0] hb_prev_q, hb_prev_d, hb_edge;
   logic [TMR_W-1:0]     timer_q [NUM_CORES];
   logic [TMR_W-1:0]     timer_d [NUM_CORES];

   always_comb begin
      hb_sync_d[0] = heartbeat_i;
      for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
         hb_sync_d[s] = hb_sync_q[s-1];
      end
      hb_prev_d = hb_sync_q[SYNC_STAGES-1];
      hb_edge   = hb_sync_q[SYNC_STAGES-1] ^ hb_prev_q;
   end

   always_ff @(posedge wb_clk or negedge wb_rst_n) begin
      if (!wb_rst_n) begin
         for (int unsigned s = 0; s < SYNC_STAGES; s++) hb_sync_q[s] <= '1;
         hb_prev_q <= '1;
         for (int unsigned i = 0; i < NUM_CORES; i++) timer_q[i] <= '0;
      end else begin
         for (int unsigned s = 0; s < SYNC_STAGES; s++) hb_sync_q[s] <= hb_sync_d[s];
         hb_prev_q <= hb_prev_d;
         for (int unsigned i = 0; i < NUM_CORES; i++) timer_q[i] <= timer_d[i];
      end
   end
`endif

   always_comb begin
      gflag_d    = gflag_q;
      cause_d    = cause_q;
      core_rst_d = '1;
      all_run_d  = 1'b1;
      for (int unsigned i = 0; i < NUM_CORES; i++) begin
         state_d[i] = state_q[i];
         cnt_d[i]   = cnt_q[i];
`ifdef BUS_SPIDER_RESET_SEQ_WDT_EN
         timer_d[i] = '0;
`endif
         unique case (state_q[i])
            ST_ASSERT: begin
               if (!(greq || hreq[i])) begin
                  state_d[i] = ST_HOLD;
                  cnt_d[i]   = gflag_q[i] ? CNT_W'(HOLD_CYCLES + i*STAGGER_CYCLES)
                                          : CNT_W'(HOLD_CYCLES);
               end
            end
            ST_HOLD: begin
               if (greq || hreq[i]) begin
                  state_d[i] = ST_ASSERT;
                  cnt_d[i]   = '0;
               end else if (cnt_q[i] == CNT_W'(1)) begin
                  state_d[i] = ST_RUN;
                  cnt_d[i]   = '0;
                  gflag_d[i] = 1'b0;
               end else begin
                  cnt_d[i] = cnt_q[i] - 1'b1;
               end
            end
            ST_RUN: begin
               // global wins over host when both arrive together
               if (greq) begin
                  state_d[i]        = ST_ASSERT;
                  gflag_d[i]        = 1'b1;
                  cause_d[2*i +: 2] = CAUSE_GLOBAL;
               end else if (hreq[i]) begin
                  state_d[i]        = ST_ASSERT;
                  cause_d[2*i +: 2] = CAUSE_HOST;
               end
`ifdef BUS_SPIDER_RESET_SEQ_WDT_EN
               else if (!hb_edge[i] && timer_q[i] == TMR_W'(WDT_CYCLES - 1)) begin
                  state_d[i]        = ST_ASSERT;
                  cause_d[2*i +: 2] = CAUSE_WDT;
               end else begin
                  timer_d[i] = hb_edge[i] ? '0 : timer_q[i] + 1'b1;
               end
`endif
            end
            default: state_d[i] = ST_ASSERT;
         endcase
         core_rst_d[i] = (state_d[i] != ST_RUN);
         all_run_d     = all_run_d & (state_d[i] == ST_RUN);
      end
   end

   always_ff @(posedge wb_clk or negedge wb_rst_n) begin
      if (!wb_rst_n) begin
         pll_sync_q <= '1;
         for (int unsigned s = 0; s < SYNC_STAGES; s++) host_sync_q[s] <= '1;
         for (int unsigned i = 0; i < NUM_CORES; i++) begin
            state_q[i] <= ST_ASSERT;
            cnt_q[i]   <= '0;
         end
         gflag_q    <= '1;
         cause_q    <= '0;
         core_rst_q <= '1;
         all_run_q  <= 1'b0;
      end else begin
         pll_sync_q <= pll_sync_d;
         for (int unsigned s = 0; s < SYNC_STAGES; s++) host_sync_q[s] <= host_sync_d[s];
         for (int unsigned i = 0; i < NUM_CORES; i++) begin
            state_q[i] <= state_d[i];
            cnt_q[i]   <= cnt_d[i];
         end
         gflag_q    <= gflag_d;
         cause_q    <= cause_d;
         core_rst_q <= core_rst_d;
         all_run_q  <= all_run_d;
      end
   end

   assign core_rst_o = core_rst_q;
   assign all_run_o  = all_run_q;
   assign cause_o    = cause_q;

endmodule
